video_field_capture: RTL and testbench
======================================

VIDEO_FIELD_CAPTURE -- requirements
Module: video_field_capture

Interface
REQ-001 Parameter PIX_PER_LINE, default 702, active pixels per line.
REQ-002 Parameter LINES_PER_FIELD, default 288, active lines per field.
REQ-003 clk  input  1  single system clock (108 MHz); all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  capture request, level.
REQ-006 video_frame_valid  input  1  field window, high for the whole active field.
REQ-007 video_line_valid  input  1  line window.
REQ-008 video_data_valid  input  1  pixel strobe, one rising edge per pixel.
REQ-009 video_data_in  input  8  pixel value.
REQ-010 video_address  input  20  {row[8:0], field[0], col[9:0]}.
REQ-011 wr_en  output  1  frame-buffer write strobe, one cycle per pixel.
REQ-012 wr_addr  output  19  progressive address.
REQ-013 wr_data  output  8  pixel value.
REQ-014 field_done  output  1  one-cycle pulse at the end of a captured field.
REQ-015 frame_done  output  1  one-cycle pulse at the end of a captured field 1.
REQ-016 capturing  output  1  high in states F0 and F1.
REQ-017 err_flags  output  4  sticky {seq_err, addr_err, field_len_err, line_len_err}.

Function
REQ-018 All video_* inputs SHALL be registered twice; edges SHALL be detected between the stage-1 and stage-2 registers.
REQ-019 Each video_data_valid rising edge SHALL be one pixel; data and address SHALL be taken from stage 1.
REQ-020 wr_en/wr_addr/wr_data SHALL be registered and valid 3 clocks after the edge that first samples video_data_valid high.
REQ-021 wr_addr SHALL equal (2*row+field)*PIX_PER_LINE+col, computed at full width, then truncated to 19 bits (max 404351).
REQ-022 A pixel with col>=PIX_PER_LINE or row>=LINES_PER_FIELD SHALL NOT be written and SHALL set addr_err.
REQ-023 FSM states: IDLE, WAIT_F0, F0, SKIP, WAIT_F1, F1.
REQ-024 IDLE: enable=1 -> WAIT_F0 and clear err_flags.
REQ-025 WAIT_F0: enable=0 -> IDLE; a frame_valid rising edge -> F0.
REQ-026 F0: the first pixel with field=1 -> SKIP with no write; all other pixels are written while field=0.
REQ-027 F0: a frame_valid falling edge -> pulse field_done, then WAIT_F1.
REQ-028 WAIT_F1: a frame_valid rising edge -> F1; enable is ignored.
REQ-029 F1: a pixel with field=0 -> set seq_err, drop the pixel, go to SKIP.
REQ-030 F1: a frame_valid falling edge -> pulse field_done and frame_done together, then WAIT_F0 if enable=1, else IDLE.
REQ-031 SKIP: no writes; a frame_valid falling edge -> WAIT_F0.
REQ-032 Pixels outside line_valid or frame_valid SHALL be ignored, with no write and no error.
REQ-033 In F0/F1, pixels per line SHALL be counted; at a line_valid falling edge, count!=PIX_PER_LINE -> set line_len_err; the counter SHALL clear at the line_valid rising edge.
REQ-034 Lines SHALL be counted on line_valid falling edges; at a frame_valid falling edge, count!=LINES_PER_FIELD -> set field_len_err; the counter SHALL clear at the frame_valid rising edge.
REQ-035 When a frame_valid falling edge and the last pixel's write fall in the same cycle, the write SHALL complete, and field_done SHALL NOT precede the last wr_en.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force state IDLE, all counters 0, wr_en/wr_addr/wr_data/field_done/frame_done/capturing/err_flags 0.
REQ-037 The frame_valid history registers SHALL reset to 1, so a field already in progress at reset release is not captured.
REQ-038 A reset mid-field SHALL abort the field with no further writes or pulses.

Configuration
REQ-039 Macro VFC_LEN_CHECK_EN defined: REQ-033/REQ-034 are implemented.
REQ-040 Macro VFC_LEN_CHECK_EN undefined: the line and field counters are omitted, and err_flags[1:0] SHALL be tied to 0; seq_err and addr_err are unaffected.

Verification
REQ-041 Stimulus: enable=1, two nominal fields (702x288, field 0 then field 1). Response: 404352 writes, addresses 0..404351 each exactly once, two field_done pulses, one frame_done, err_flags=0.
REQ-042 Stimulus: first field after enable carries field=1. Response: SKIP, no writes, no field_done; the next field-0/field-1 pair captured normally.
REQ-043 Stimulus: one line of 701 pixels in field 0. Response: line_len_err=1, field_len_err=0, row 0 col 0 field 1 written at wr_addr=702.
REQ-044 Stimulus: pixel with col=702. Response: no wr_en, addr_err=1; then enable low, then high. Response: err_flags cleared.
REQ-045 Stimulus: rst_n low for 1 cycle at line 100 of F0, with frame_valid still high. Response: all outputs 0, no writes until the next frame_valid rising edge.
REQ-046 Stimulus: pixel strobe. Response: wr_en exactly 3 clocks after first high sample, wr_data equal to the pixel value.

Source files
------------

// File: rtl/video_field_capture_if.sv
// rtl/video_field_capture_if.sv - video source and frame-buffer write bundle
// master drives the video window/pixel signals and observes writes; slave is the capture block.
interface video_field_capture_if;
   logic        video_frame_valid;
   logic        video_line_valid;
   logic        video_data_valid;
   logic [7:0]  video_data_in;
   logic [19:0] video_address;
   logic        wr_en;
   logic [18:0] wr_addr;
   logic [7:0]  wr_data;

   modport master (
      output video_frame_valid, video_line_valid, video_data_valid, video_data_in, video_address,
      input  wr_en, wr_addr, wr_data
   );

   modport slave (
      input  video_frame_valid, video_line_valid, video_data_valid, video_data_in, video_address,
      output wr_en, wr_addr, wr_data
   );
endinterface

// File: rtl/video_field_capture.sv
// rtl/video_field_capture.sv - interlaced field capture into a progressive frame buffer
// Optional line/field length checking is compiled in with VFC_LEN_CHECK_EN.
module video_field_capture #(
   parameter int PIX_PER_LINE    = 702,
   parameter int LINES_PER_FIELD = 288
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   video_field_capture_if.slave  vif,
   output logic                  field_done,
   output logic                  frame_done,
   output logic                  capturing,
   output logic [3:0]            err_flags
);

   typedef enum logic [2:0] {IDLE, WAIT_F0, F0, SKIP, WAIT_F1, F1} state_t;

   localparam logic [10:0] PPL_W = 11'(PIX_PER_LINE);
   localparam logic [9:0]  LPF_W = 10'(LINES_PER_FIELD);

   state_t state_q, state_d;

   logic fv_s1_q, fv_s1_d, fv_s2_q, fv_s2_d;
   logic lv_s1_q, lv_s1_d, lv_s2_q, lv_s2_d;
   logic dv_s1_q, dv_s1_d, dv_s2_q, dv_s2_d;
   logic [7:0]  data_s1_q, data_s1_d, data_s2_q, data_s2_d;
   logic [19:0] addr_s1_q, addr_s1_d, addr_s2_q, addr_s2_d;

   logic        p1_valid_q, p1_valid_d;
   logic        p2_valid_q, p2_valid_d;
   logic [18:0] p2_addr_q, p2_addr_d;
   logic [7:0]  p2_data_q, p2_data_d;
   logic        wr_en_q, wr_en_d;
   logic [18:0] wr_addr_q, wr_addr_d;
   logic [7:0]  wr_data_q, wr_data_d;

   logic field_p1_q, field_p1_d, field_p2_q, field_p2_d, field_done_q, field_done_d;
   logic frame_p1_q, frame_p1_d, frame_p2_q, frame_p2_d, frame_done_q, frame_done_d;

   logic seq_err_q, seq_err_d, addr_err_q, addr_err_d;

   logic fv_rise, fv_fall, lv_rise, lv_fall, pix_evt, pix_field, in_range, capt;

   assign fv_rise   = fv_s1_q & ~fv_s2_q;
   assign fv_fall   = ~fv_s1_q & fv_s2_q;
   assign lv_rise   = lv_s1_q & ~lv_s2_q;
   assign lv_fall   = ~lv_s1_q & lv_s2_q;
   // A pixel is a strobe rising edge inside both windows, judged on the stage-1 sample.
   assign pix_evt   = dv_s1_q & ~dv_s2_q & lv_s1_q & fv_s1_q;
   assign pix_field = addr_s1_q[10];
   assign in_range  = ({1'b0, addr_s1_q[9:0]} < PPL_W) && ({1'b0, addr_s1_q[19:11]} < LPF_W);
   assign capt      = (state_q == F0) || (state_q == F1);

`ifdef VFC_LEN_CHECK_EN
   logic [10:0] pix_cnt_q, pix_cnt_d;
   logic [9:0]  line_cnt_q, line_cnt_d, line_cnt_inc;
   logic        line_len_err_q, line_len_err_d, field_len_err_q, field_len_err_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      seq_err_d  = seq_err_q;
      addr_err_d = addr_err_q;
      p1_valid_d = 1'b0;
      field_p1_d = 1'b0;
      frame_p1_d = 1'b0;
`ifdef VFC_LEN_CHECK_EN
      line_len_err_d  = line_len_err_q;
      field_len_err_d = field_len_err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d    = WAIT_F0;
               seq_err_d  = 1'b0;
               addr_err_d = 1'b0;
`ifdef VFC_LEN_CHECK_EN
               line_len_err_d  = 1'b0;
               field_len_err_d = 1'b0;
`endif
            end
         end
         WAIT_F0: begin
            if (!enable) begin
               state_d = IDLE;
            end else if (fv_rise) begin
               state_d = F0;
            end
         end
         F0: begin
            if (fv_fall) begin
               field_p1_d = 1'b1;
               state_d    = WAIT_F1;
            end else if (pix_evt) begin
               if (pix_field) begin
                  state_d = SKIP;
               end else if (!in_range) begin
                  addr_err_d = 1'b1;
               end else begin
                  p1_valid_d = 1'b1;
               end
            end
         end
         SKIP: begin
            if (fv_fall) begin
               state_d = WAIT_F0;
            end
         end
         WAIT_F1: begin
            if (fv_rise) begin
               state_d = F1;
            end
         end
         F1: begin
            if (fv_fall) begin
               field_p1_d = 1'b1;
               frame_p1_d = 1'b1;
               state_d    = enable ? WAIT_F0 : IDLE;
            end else if (pix_evt) begin
               if (!pix_field) begin
                  seq_err_d = 1'b1;
                  state_d   = SKIP;
               end else if (!in_range) begin
                  addr_err_d = 1'b1;
               end else begin
                  p1_valid_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
`ifdef VFC_LEN_CHECK_EN
      if (capt) begin
         if (lv_fall && (pix_cnt_q != PPL_W)) begin
            line_len_err_d = 1'b1;
         end
         // line_cnt_inc folds in a line that ends in the same cycle as the field.
         if (fv_fall && (line_cnt_inc != LPF_W)) begin
            field_len_err_d = 1'b1;
         end
      end
`endif
   end

   always_comb begin
      fv_s1_d   = vif.video_frame_valid;
      fv_s2_d   = fv_s1_q;
      lv_s1_d   = vif.video_line_valid;
      lv_s2_d   = lv_s1_q;
      dv_s1_d   = vif.video_data_valid;
      dv_s2_d   = dv_s1_q;
      data_s1_d = vif.video_data_in;
      data_s2_d = data_s1_q;
      addr_s1_d = vif.video_address;
      addr_s2_d = addr_s1_q;

      // Stage 2 holds the stage-1 sample of the accepted pixel when p1_valid_q is set.
      p2_valid_d = p1_valid_q;
      p2_addr_d  = 19'({22'd0, addr_s2_q[19:10]} * 32'(PIX_PER_LINE) + {22'd0, addr_s2_q[9:0]});
      p2_data_d  = data_s2_q;
      wr_en_d    = p2_valid_q;
      wr_addr_d  = p2_valid_q ? p2_addr_q : wr_addr_q;
      wr_data_d  = p2_valid_q ? p2_data_q : wr_data_q;

      field_p2_d   = field_p1_q;
      field_done_d = field_p2_q;
      frame_p2_d   = frame_p1_q;
      frame_done_d = frame_p2_q;

`ifdef VFC_LEN_CHECK_EN
      pix_cnt_d = pix_cnt_q;
      if (lv_rise) begin
         pix_cnt_d = '0;
      end else if (capt && pix_evt && (pix_cnt_q != '1)) begin
         pix_cnt_d = pix_cnt_q + 11'd1;
      end
      line_cnt_inc = line_cnt_q;
      if (capt && lv_fall && (line_cnt_q != '1)) begin
         line_cnt_inc = line_cnt_q + 10'd1;
      end
      line_cnt_d = fv_rise ? '0 : line_cnt_inc;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         // Frame history starts high so a field already running at release is ignored.
         fv_s1_q      <= 1'b1;
         fv_s2_q      <= 1'b1;
         lv_s1_q      <= 1'b0;
         lv_s2_q      <= 1'b0;
         dv_s1_q      <= 1'b0;
         dv_s2_q      <= 1'b0;
         data_s1_q    <= '0;
         data_s2_q    <= '0;
         addr_s1_q    <= '0;
         addr_s2_q    <= '0;
         p1_valid_q   <= 1'b0;
         p2_valid_q   <= 1'b0;
         p2_addr_q    <= '0;
         p2_data_q    <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         field_p1_q   <= 1'b0;
         field_p2_q   <= 1'b0;
         field_done_q <= 1'b0;
         frame_p1_q   <= 1'b0;
         frame_p2_q   <= 1'b0;
         frame_done_q <= 1'b0;
         seq_err_q    <= 1'b0;
         addr_err_q   <= 1'b0;
`ifdef VFC_LEN_CHECK_EN
         pix_cnt_q       <= '0;
         line_cnt_q      <= '0;
         line_len_err_q  <= 1'b0;
         field_len_err_q <= 1'b0;
`endif
      end else begin
         fv_s1_q      <= fv_s1_d;
         fv_s2_q      <= fv_s2_d;
         lv_s1_q      <= lv_s1_d;
         lv_s2_q      <= lv_s2_d;
         dv_s1_q      <= dv_s1_d;
         dv_s2_q      <= dv_s2_d;
         data_s1_q    <= data_s1_d;
         data_s2_q    <= data_s2_d;
         addr_s1_q    <= addr_s1_d;
         addr_s2_q    <= addr_s2_d;
         p1_valid_q   <= p1_valid_d;
         p2_valid_q   <= p2_valid_d;
         p2_addr_q    <= p2_addr_d;
         p2_data_q    <= p2_data_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         field_p1_q   <= field_p1_d;
         field_p2_q   <= field_p2_d;
         field_done_q <= field_done_d;
         frame_p1_q   <= frame_p1_d;
         frame_p2_q   <= frame_p2_d;
         frame_done_q <= frame_done_d;
         seq_err_q    <= seq_err_d;
         addr_err_q   <= addr_err_d;
`ifdef VFC_LEN_CHECK_EN
         pix_cnt_q       <= pix_cnt_d;
         line_cnt_q      <= line_cnt_d;
         line_len_err_q  <= line_len_err_d;
         field_len_err_q <= field_len_err_d;
`endif
      end
   end

   assign vif.wr_en   = wr_en_q;
   assign vif.wr_addr = wr_addr_q;
   assign vif.wr_data = wr_data_q;
   assign field_done  = field_done_q;
   assign frame_done  = frame_done_q;
   assign capturing   = capt;
`ifdef VFC_LEN_CHECK_EN
   assign err_flags = {seq_err_q, addr_err_q, field_len_err_q, line_len_err_q};
`else
   assign err_flags = {seq_err_q, addr_err_q, 2'b00};
`endif

endmodule

// File: tb/tb_video_field_capture.sv
// tb/tb_video_field_capture.sv - directed bench for video_field_capture
// Small geometry (6 pixels x 3 lines) keeps whole fields short.
`timescale 1ns/1ps
module tb_video_field_capture;
   localparam int PPL = 6;
   localparam int LPF = 3;
`ifdef VFC_LEN_CHECK_EN
   localparam logic [3:0] LINE_ERR = 4'b0001;
`else
   localparam logic [3:0] LINE_ERR = 4'b0000;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       field_done, frame_done, capturing;
   logic [3:0] err_flags;

   video_field_capture_if vif();

   video_field_capture #(.PIX_PER_LINE(PPL), .LINES_PER_FIELD(LPF)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .vif(vif),
      .field_done(field_done), .frame_done(frame_done),
      .capturing(capturing), .err_flags(err_flags)
   );

   always #5 clk = ~clk;

   int n_tests = 0, n_fail = 0;
   int cyc = 0, fd_cnt = 0, fr_cnt = 0, last_wr_cyc = 0, last_fd_cyc = 0;
   logic [18:0] got_addr[$], exp_addr[$];
   logic [7:0]  got_data[$], exp_data[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (vif.wr_en === 1'b1) begin
         got_addr.push_back(vif.wr_addr);
         got_data.push_back(vif.wr_data);
         last_wr_cyc = cyc;
      end
      if (field_done === 1'b1) begin
         fd_cnt++;
         last_fd_cyc = cyc;
      end
      if (frame_done === 1'b1) fr_cnt++;
   end

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_log();
      got_addr.delete(); got_data.delete();
      exp_addr.delete(); exp_data.delete();
   endtask

   task automatic set_pixel(input int row, input int fld, input int col);
      vif.video_address = {9'(row), 1'(fld), 10'(col)};
      vif.video_data_in = 8'(row * 16 + fld * 8 + col);
   endtask

   task automatic expect_pixel(input int row, input int fld, input int col);
      exp_addr.push_back(19'((2 * row + fld) * PPL + col));
      exp_data.push_back(8'(row * 16 + fld * 8 + col));
   endtask

   task automatic send_pixel(input int row, input int fld, input int col, input bit exp_wr);
      set_pixel(row, fld, col);
      vif.video_data_valid = 1'b1;
      tick(2);
      vif.video_data_valid = 1'b0;
      tick(2);
      if (exp_wr) expect_pixel(row, fld, col);
   endtask

   task automatic send_line(input int row, input int fld, input int npix, input bit exp_wr);
      vif.video_line_valid = 1'b1;
      tick(2);
      for (int c = 0; c < npix; c++) send_pixel(row, fld, c, exp_wr);
      vif.video_line_valid = 1'b0;
      tick(2);
   endtask

   task automatic send_field(input int pix_fld, input bit exp_wr);
      vif.video_frame_valid = 1'b1;
      tick(3);
      for (int r = 0; r < LPF; r++) send_line(r, pix_fld, PPL, exp_wr);
      vif.video_frame_valid = 1'b0;
      tick(8);
   endtask

   task automatic check_log(input string name);
      int bad = 0;
      foreach (exp_addr[i]) begin
         if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i]) bad++;
      end
      n_tests++;
      if (got_addr.size() != exp_addr.size() || bad != 0) begin
         n_fail++;
         $display("FAIL %s: got %0d writes (%0d wrong), expected %0d writes", name, got_addr.size(), bad, exp_addr.size());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(3);
      n_tests++; if (vif.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en: got %b, expected 0", vif.wr_en); end
      n_tests++; if (field_done !== 1'b0) begin n_fail++; $display("FAIL reset_field_done: got %b, expected 0", field_done); end
      n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b, expected 0", frame_done); end
      n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL reset_capturing: got %b, expected 0", capturing); end
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL reset_err_flags: got %b, expected 0000", err_flags); end
      rst_n = 1'b1;
      tick(2);
   endtask

   task automatic test_nominal();
      int fd0 = fd_cnt, fr0 = fr_cnt, once = 0;
      int seen[2*PPL*LPF];
      clear_log();
      enable = 1'b1;
      tick(3);
      send_field(0, 1'b1);
      send_field(1, 1'b1);
      check_log("nominal_writes");
      foreach (seen[i]) seen[i] = 0;
      foreach (got_addr[i]) if (got_addr[i] < 19'(2 * PPL * LPF)) seen[got_addr[i]]++;
      foreach (seen[i]) if (seen[i] == 1) once++;
      n_tests++; if (once != 2 * PPL * LPF) begin n_fail++; $display("FAIL nominal_coverage: got %0d addresses written once, expected %0d", once, 2 * PPL * LPF); end
      n_tests++; if (fd_cnt - fd0 != 2) begin n_fail++; $display("FAIL nominal_field_done: got %0d, expected 2", fd_cnt - fd0); end
      n_tests++; if (fr_cnt - fr0 != 1) begin n_fail++; $display("FAIL nominal_frame_done: got %0d, expected 1", fr_cnt - fr0); end
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL nominal_err_flags: got %b, expected 0000", err_flags); end
      n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL nominal_capturing: got %b, expected 0", capturing); end
   endtask

   task automatic test_skip_first();
      int fd0 = fd_cnt, fr0 = fr_cnt;
      clear_log();
      send_field(1, 1'b0);
      n_tests++; if (got_addr.size() != 0 || fd_cnt != fd0) begin n_fail++; $display("FAIL skip_field: got %0d writes %0d field_done, expected 0 and 0", got_addr.size(), fd_cnt - fd0); end
      send_field(0, 1'b1);
      send_field(1, 1'b1);
      check_log("skip_then_pair");
      n_tests++; if (fd_cnt - fd0 != 2 || fr_cnt - fr0 != 1) begin n_fail++; $display("FAIL skip_pulses: got fd %0d fr %0d, expected 2 and 1", fd_cnt - fd0, fr_cnt - fr0); end
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL skip_err_flags: got %b, expected 0000", err_flags); end
   endtask

   task automatic test_short_line();
      bit found = 1'b0;
      clear_log();
      vif.video_frame_valid = 1'b1;
      tick(3);
      send_line(0, 0, PPL - 1, 1'b1);
      send_line(1, 0, PPL, 1'b1);
      send_line(2, 0, PPL, 1'b1);
      vif.video_frame_valid = 1'b0;
      tick(8);
      send_field(1, 1'b1);
      check_log("short_line_writes");
      foreach (got_addr[i]) if (got_addr[i] == 19'(PPL) && got_data[i] == 8'd8) found = 1'b1;
      n_tests++; if (!found) begin n_fail++; $display("FAIL short_line_f1_row0: got no write of 8 at %0d, expected one", PPL); end
      n_tests++; if (err_flags !== LINE_ERR) begin n_fail++; $display("FAIL short_line_err_flags: got %b, expected %b", err_flags, LINE_ERR); end
      enable = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(2);
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL short_line_clear: got %b, expected 0000", err_flags); end
   endtask

   task automatic test_addr_err();
      clear_log();
      vif.video_frame_valid = 1'b1;
      tick(3);
      vif.video_line_valid = 1'b1;
      tick(2);
      for (int c = 0; c < PPL - 1; c++) send_pixel(0, 0, c, 1'b1);
      send_pixel(0, 0, PPL, 1'b0);
      vif.video_line_valid = 1'b0;
      tick(2);
      send_line(1, 0, PPL, 1'b1);
      send_line(2, 0, PPL, 1'b1);
      vif.video_frame_valid = 1'b0;
      tick(8);
      check_log("addr_err_writes");
      n_tests++; if (err_flags !== 4'b0100) begin n_fail++; $display("FAIL addr_err_flags: got %b, expected 0100", err_flags); end
      send_field(1, 1'b1);
      enable = 1'b0;
      tick(3);
      enable = 1'b1;
      tick(2);
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL addr_err_clear: got %b, expected 0000", err_flags); end
   endtask

   task automatic test_seq_err();
      int fd0 = fd_cnt, fr0 = fr_cnt;
      clear_log();
      send_field(0, 1'b1);
      send_field(0, 1'b0);
      check_log("seq_err_writes");
      n_tests++; if (fd_cnt - fd0 != 1 || fr_cnt - fr0 != 0) begin n_fail++; $display("FAIL seq_err_pulses: got fd %0d fr %0d, expected 1 and 0", fd_cnt - fd0, fr_cnt - fr0); end
      n_tests++; if (err_flags !== 4'b1000) begin n_fail++; $display("FAIL seq_err_flags: got %b, expected 1000", err_flags); end
   endtask

   task automatic test_back_to_back();
      int fd0 = fd_cnt;
      clear_log();
      vif.video_frame_valid = 1'b1;
      tick(3);
      send_line(0, 0, PPL, 1'b1);
      send_line(1, 0, PPL, 1'b1);
      vif.video_line_valid = 1'b1;
      tick(2);
      for (int c = 0; c < PPL - 1; c++) send_pixel(2, 0, c, 1'b1);
      set_pixel(2, 0, PPL - 1);
      vif.video_data_valid = 1'b1;
      tick(2);
      vif.video_data_valid = 1'b0;
      vif.video_line_valid = 1'b0;
      vif.video_frame_valid = 1'b0;
      expect_pixel(2, 0, PPL - 1);
      tick(10);
      check_log("b2b_writes");
      n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL b2b_field_done: got %0d, expected 1", fd_cnt - fd0); end
      n_tests++; if (last_fd_cyc < last_wr_cyc) begin n_fail++; $display("FAIL b2b_order: got field_done cycle %0d, expected >= last write cycle %0d", last_fd_cyc, last_wr_cyc); end
   endtask

   task automatic test_latency();
      vif.video_frame_valid = 1'b1;
      tick(3);
      n_tests++; if (capturing !== 1'b1) begin n_fail++; $display("FAIL latency_capturing: got %b, expected 1", capturing); end
      vif.video_line_valid = 1'b1;
      tick(2);
      vif.video_address = {9'd0, 1'b1, 10'd0};
      vif.video_data_in = 8'hA5;
      vif.video_data_valid = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #2;
         if (k == 2) vif.video_data_valid = 1'b0;
         n_tests++;
         if (vif.wr_en !== (k == 4)) begin n_fail++; $display("FAIL latency_wr_en_clk%0d: got %b, expected %b", k, vif.wr_en, (k == 4)); end
      end
      n_tests++; if (vif.wr_data !== 8'hA5) begin n_fail++; $display("FAIL latency_wr_data: got %h, expected a5", vif.wr_data); end
      n_tests++; if (vif.wr_addr !== 19'(PPL)) begin n_fail++; $display("FAIL latency_wr_addr: got %0d, expected %0d", vif.wr_addr, PPL); end
      tick(2);
      vif.video_line_valid = 1'b0;
      tick(2);
   endtask

   task automatic test_reset_mid();
      int fd0, fr0;
      clear_log();
      send_line(1, 1, PPL, 1'b1);
      rst_n = 1'b0;
      tick(1);
      n_tests++; if (vif.wr_en !== 1'b0 || field_done !== 1'b0 || frame_done !== 1'b0) begin n_fail++; $display("FAIL midreset_strobes: got %b%b%b, expected 000", vif.wr_en, field_done, frame_done); end
      n_tests++; if (capturing !== 1'b0) begin n_fail++; $display("FAIL midreset_capturing: got %b, expected 0", capturing); end
      n_tests++; if (err_flags !== 4'b0) begin n_fail++; $display("FAIL midreset_err_flags: got %b, expected 0000", err_flags); end
      n_tests++; if (vif.wr_addr !== 19'd0 || vif.wr_data !== 8'd0) begin n_fail++; $display("FAIL midreset_wr_bus: got %0d/%h, expected 0/00", vif.wr_addr, vif.wr_data); end
      rst_n = 1'b1;
      fd0 = fd_cnt;
      fr0 = fr_cnt;
      send_line(2, 1, PPL, 1'b0);
      vif.video_frame_valid = 1'b0;
      tick(8);
      n_tests++; if (fd_cnt != fd0 || fr_cnt != fr0) begin n_fail++; $display("FAIL midreset_no_pulse: got fd %0d fr %0d, expected 0 and 0", fd_cnt - fd0, fr_cnt - fr0); end
      send_field(0, 1'b1);
      check_log("midreset_writes");
      n_tests++; if (fd_cnt - fd0 != 1) begin n_fail++; $display("FAIL midreset_recover: got %0d field_done, expected 1", fd_cnt - fd0); end
   endtask

   initial begin
      vif.video_frame_valid = 1'b0;
      vif.video_line_valid  = 1'b0;
      vif.video_data_valid  = 1'b0;
      vif.video_data_in     = '0;
      vif.video_address     = '0;
      test_reset();
      test_nominal();
      test_skip_first();
      test_short_line();
      test_addr_err();
      test_seq_err();
      test_back_to_back();
      test_latency();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
